// File: rtl/spi_xfer_ctrl.sv
// SPI master frame sequencer: drives cs_n/sclk/mosi from spi_prescaler half-period ticks,
// samples miso into a word and forwards prescaler configuration (deferred while a frame runs).
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_stb_i,
  input  logic [15:0]           cfg_prescaler_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  prescaler_stb_o,
  output logic [15:0]           prescaler_o,
  input  logic                  high_pulse_i,
  input  logic                  low_pulse_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o
);

  localparam int               CNT_W     = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  typedef struct packed {
    state_t                state;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic                  cpol;
    logic                  cpha;
    logic [CNT_W-1:0]      edge_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  pre_stb;
    logic [15:0]           pre_val;
    logic                  pend_valid;
    logic [15:0]           pend_val;
  } regs_t;

  regs_t q, d;
  logic  tick;
  logic  accept;
  logic  leading;

  assign tick       = high_pulse_i | low_pulse_i;
  assign tx_ready_o = (q.state == IDLE) && !q.pend_valid;
  assign busy_o     = (q.state != IDLE);
  assign accept     = tx_valid_i && tx_ready_o;
  // edge_cnt counts ticks already taken, so the current tick is odd (leading) when it is even.
  assign leading    = !q.edge_cnt[0];

  always_comb begin
    // NOTE: every field starts from its held value so no path leaves a variable unassigned (no latches).
    d          = q;
    d.rx_valid = 1'b0;
    d.pre_stb  = 1'b0;

    if (cfg_stb_i) begin
      if (q.state == IDLE) begin
        d.pre_val    = cfg_prescaler_i;
        d.pre_stb    = 1'b1;
        d.pend_valid = 1'b0;
      end else begin
        d.pend_valid = 1'b1;
        d.pend_val   = cfg_prescaler_i;
      end
    end else if (q.state == IDLE && q.pend_valid) begin
      d.pre_val    = q.pend_val;
      d.pre_stb    = 1'b1;
      d.pend_valid = 1'b0;
    end

    case (q.state)
      IDLE: begin
        d.sclk = cpol_i;
        if (accept) begin
          d.tx_shift = tx_data_i;
          d.cpol     = cpol_i;
          d.cpha     = cpha_i;
          d.cs_n     = 1'b0;
          if (!cpha_i) d.mosi = tx_data_i[DATA_WIDTH-1];
          d.state = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          d.edge_cnt = '0;
          d.state    = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          d.sclk     = ~q.sclk;
          d.edge_cnt = q.edge_cnt + 1'b1;
          if (leading) begin
            if (q.cpha) begin
              d.mosi     = q.tx_shift[DATA_WIDTH-1];
              d.tx_shift = q.tx_shift << 1;
            end else begin
              d.rx_shift = {q.rx_shift[DATA_WIDTH-2:0], miso_i};
            end
          end else begin
            if (q.cpha) begin
              d.rx_shift = {q.rx_shift[DATA_WIDTH-2:0], miso_i};
            end else if (q.edge_cnt != LAST_EDGE) begin
              d.mosi     = q.tx_shift[DATA_WIDTH-2];
              d.tx_shift = q.tx_shift << 1;
            end
          end
          if (q.edge_cnt == LAST_EDGE) d.state = TRAIL;
        end
      end
      TRAIL: begin
        if (tick) begin
          d.sclk     = q.cpol;
          d.cs_n     = 1'b1;
          d.rx_valid = 1'b1;
          d.rx_data  = q.rx_shift;
          d.state    = IDLE;
        end
      end
      default: d.state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) begin
      q       <= '0;
      q.state <= IDLE;
      q.cs_n  <= 1'b1;
    end else begin
      q <= d;
    end
  end

  assign cs_n_o          = q.cs_n;
  assign sclk_o          = q.sclk;
  assign mosi_o          = q.mosi;
  assign rx_valid_o      = q.rx_valid;
  assign rx_data_o       = q.rx_data;
  assign prescaler_stb_o = q.pre_stb;
  assign prescaler_o     = q.pre_val;

endmodule
